frontpanel_spi_scheduler: RTL

Owns the front panel SPI link: it sequences chip select and byte shifts into the SPI host shift engine. It shares the link between two requesters: a periodic LED refresh frame generated internally from the trigger LED state, and software byte transactions issued by the management register interface. It sits between the register interface and the SPI host in the management subsystem, in the sys_clk domain.

---
 rtl/frontpanel_spi_scheduler_pkg.sv | 7 +
 rtl/frontpanel_led_framer.sv | 28 ++
 rtl/frontpanel_spi_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/frontpanel_spi_scheduler_pkg.sv
// frontpanel_spi_scheduler_pkg: front panel SPI frame constants and scheduler types
package frontpanel_spi_scheduler_pkg;
    localparam logic [7:0] LED_OPCODE = 8'hA5;
    localparam int FRAME_LEN = 4;
    typedef enum logic [2:0] {IDLE, SETUP, LOAD, SW_WAIT, SHIFT, HOLD} state_t;
    typedef enum logic {GRANT_LED, GRANT_SW} grant_t;
endpackage

// File: rtl/frontpanel_led_framer.sv
// frontpanel_led_framer: snapshots LED state at grant and selects LED frame byte by index
module frontpanel_led_framer
    import frontpanel_spi_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        snap,
    input  logic [11:0] trig_in_led,
    input  logic [11:0] trig_out_led,
    input  logic [1:0]  idx,
    output logic [7:0]  frame_byte
);
    logic [11:0] in_q, out_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q  <= '0;
            out_q <= '0;
        end else if (snap) begin
            in_q  <= trig_in_led;
            out_q <= trig_out_led;
        end
    end
    always_comb begin
        frame_byte = idx == 2'd0 ? LED_OPCODE :
                     idx == 2'd1 ? in_q[11:4] :
                     idx == 2'd2 ? {in_q[3:0], out_q[11:8]} : out_q[7:0];
    end
endmodule

// File: rtl/frontpanel_spi_scheduler.sv
// frontpanel_spi_scheduler: shares the front panel SPI link between LED refresh frames and software bytes
module frontpanel_spi_scheduler
    import frontpanel_spi_scheduler_pkg::*;
#(
    parameter int REFRESH_DIV = 250000,
    parameter int CS_GUARD    = 8,
    parameter int SW_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] trig_in_led,
    input  logic [11:0] trig_out_led,
    input  logic        sw_req,
    input  logic [7:0]  sw_data,
    input  logic        sw_last,
    output logic        sw_ack,
    output logic        sw_busy,
    output logic        sw_abort,
    output logic        shift_en,
    output logic [7:0]  shift_data,
    input  logic        shift_done,
    output logic        cs_n,
    output logic [15:0] refresh_count
);
    localparam int IW = $clog2(SW_TIMEOUT + 1);
    state_t        state;
    grant_t        last_grant;
    logic [23:0]   tmr;
    logic          led_pending, last_q, guard_ok, grant_led, grant_sw, wrap;
    logic [7:0]    cnt, led_byte;
    logic [IW-1:0] idle_cnt;
    logic [1:0]    idx;
    frontpanel_led_framer u_framer (
        .clk          (clk),
        .rst          (rst),
        .snap         (grant_led),
        .trig_in_led  (trig_in_led),
        .trig_out_led (trig_out_led),
        .idx          (idx),
        .frame_byte   (led_byte)
    );
    // last_grant doubles as the owner of the current transaction
    always_comb begin
        wrap      = tmr == 24'(REFRESH_DIV - 1);
        guard_ok  = state == IDLE && cnt >= 8'(CS_GUARD - 1);
        grant_led = guard_ok && led_pending && (!sw_req || last_grant == GRANT_SW);
        grant_sw  = guard_ok && sw_req && !grant_led;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= GRANT_LED;
            tmr           <= '0;
            led_pending   <= 1'b0;
            last_q        <= 1'b0;
            cnt           <= '0;
            idle_cnt      <= '0;
            idx           <= '0;
            cs_n          <= 1'b1;
            shift_en      <= 1'b0;
            shift_data    <= '0;
            sw_ack        <= 1'b0;
            sw_busy       <= 1'b0;
            sw_abort      <= 1'b0;
            refresh_count <= '0;
        end else begin
            shift_en <= 1'b0;
            sw_ack   <= 1'b0;
            sw_abort <= 1'b0;
            tmr      <= wrap ? '0 : tmr + 24'd1;
            if (grant_led) led_pending <= 1'b0;
            if (wrap) led_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (cnt != 8'hFF) cnt <= cnt + 8'd1;
                    if (grant_led || grant_sw) begin
                        cs_n       <= 1'b0;
                        cnt        <= '0;
                        idx        <= '0;
                        last_grant <= grant_led ? GRANT_LED : GRANT_SW;
                        sw_busy    <= grant_sw;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    cnt      <= cnt + 8'd1;
                    idle_cnt <= '0;
                    if (cnt == 8'(CS_GUARD - 1)) begin
                        cnt   <= '0;
                        state <= last_grant == GRANT_LED ? LOAD : SW_WAIT;
                    end
                end
                LOAD: begin
                    shift_en   <= 1'b1;
                    shift_data <= led_byte;
                    state      <= SHIFT;
                end
                SW_WAIT: begin
                    if (sw_req) begin
                        shift_en   <= 1'b1;
                        shift_data <= sw_data;
                        sw_ack     <= 1'b1;
                        last_q     <= sw_last;
                        state      <= SHIFT;
                    end else if (idle_cnt == IW'(SW_TIMEOUT - 1)) begin
                        sw_abort <= 1'b1;
                        cnt      <= '0;
                        state    <= HOLD;
                    end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                SHIFT: begin
                    if (shift_done) begin
                        cnt      <= '0;
                        idle_cnt <= '0;
                        idx      <= idx + 2'd1;
                        state    <= last_grant == GRANT_LED ? (idx == 2'(FRAME_LEN - 1) ? HOLD : LOAD)
                                                            : (last_q ? HOLD : SW_WAIT);
                    end
                end
                HOLD: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'(CS_GUARD - 1)) begin
                        cs_n    <= 1'b1;
                        sw_busy <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                        if (last_grant == GRANT_LED) refresh_count <= refresh_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
